// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - LEGv8 ALU control decode plus execute unit with iterative multiply
// Single-cycle ops register in one edge; MUL runs a radix-2 shift-add over WIDTH cycles.
module alu_exec_ctrl #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [31:0]      instruction,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       operation_code,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             illegal,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_ORR  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_LSL  = 4'b1001;
   localparam logic [3:0] OP_LSR  = 4'b1010;
   localparam logic [3:0] OP_ILL  = 4'b1111;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t state, next_state;

   logic [WIDTH-1:0] mcand, mplier, acc;
   logic [CW-1:0]    cnt;

   logic [3:0]       dec_code;
   logic             dec_illegal;
   logic [WIDTH-1:0] ex_result;
   logic             ex_carry, ex_ovf;
   logic [WIDTH:0]   add_full;
   logic [WIDTH-1:0] sub_res;
   logic [5:0]       shamt;
   logic             shamt_big;
   logic [WIDTH-1:0] mul_final;
   logic             xfer, mul_done;

   assign in_ready  = rst_n & (state == S_IDLE) & (~out_valid | out_ready);
   assign xfer      = in_valid & in_ready;
   assign busy      = (state == S_MUL);
   assign mul_done  = (state == S_MUL) && (cnt == CW'(1));
   assign mul_final = acc + (mplier[0] ? mcand : '0);
   assign shamt     = instruction[15:10];
   assign shamt_big = ({26'd0, shamt} >= WIDTH);
   assign add_full  = {1'b0, operand_a} + {1'b0, operand_b};
   assign sub_res   = operand_a - operand_b;

   always_comb begin
      dec_code    = OP_ILL;
      dec_illegal = 1'b0;
      if (alu_op == 2'b00) begin
         dec_code = OP_ADD;
      end else if (alu_op[0]) begin
         dec_code = OP_PASS;
      end else begin
         case (instruction[31:21])
            11'b10001011000: dec_code = OP_ADD;
            11'b11001011000: dec_code = OP_SUB;
            11'b10001010000: dec_code = OP_AND;
            11'b10101010000: dec_code = OP_ORR;
            11'b10011011000: dec_code = OP_MUL;
            11'b11010011011: dec_code = OP_LSL;
            11'b11010011010: dec_code = OP_LSR;
            default: begin
               dec_code    = OP_ILL;
               dec_illegal = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      ex_result = '0;
      ex_carry  = 1'b0;
      ex_ovf    = 1'b0;
      case (dec_code)
         OP_ADD: begin
            ex_result = add_full[WIDTH-1:0];
            ex_carry  = add_full[WIDTH];
            ex_ovf    = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                        (add_full[WIDTH-1] != operand_a[WIDTH-1]);
         end
         OP_SUB: begin
            ex_result = sub_res;
            ex_carry  = (operand_a >= operand_b);
            ex_ovf    = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                        (sub_res[WIDTH-1] != operand_a[WIDTH-1]);
         end
         OP_AND:  ex_result = operand_a & operand_b;
         OP_ORR:  ex_result = operand_a | operand_b;
         OP_PASS: ex_result = operand_b;
         OP_LSL:  ex_result = shamt_big ? '0 : (operand_a << shamt);
         OP_LSR:  ex_result = shamt_big ? '0 : (operand_a >> shamt);
         default: ex_result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (xfer && dec_code == OP_MUL) next_state = S_MUL;
         S_MUL:   if (mul_done) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         result         <= '0;
         operation_code <= 4'b0000;
         zero           <= 1'b0;
         negative       <= 1'b0;
         carry          <= 1'b0;
         overflow       <= 1'b0;
         illegal        <= 1'b0;
         mcand          <= '0;
         mplier         <= '0;
         acc            <= '0;
         cnt            <= '0;
      end else begin
         if (mul_done) begin
            out_valid      <= 1'b1;
            result         <= mul_final;
            operation_code <= OP_MUL;
            zero           <= (mul_final == '0);
            negative       <= mul_final[WIDTH-1];
            carry          <= 1'b0;
            overflow       <= 1'b0;
            illegal        <= 1'b0;
         end else if (xfer && dec_code != OP_MUL) begin
            out_valid      <= 1'b1;
            result         <= ex_result;
            operation_code <= dec_code;
            zero           <= (ex_result == '0);
            negative       <= ex_result[WIDTH-1];
            carry          <= ex_carry;
            overflow       <= ex_ovf;
            illegal        <= dec_illegal;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         // Operands are captured only here, so later input changes cannot disturb the multiply
         if (xfer && dec_code == OP_MUL) begin
            mcand  <= operand_a;
            mplier <= operand_b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
         end else if (state == S_MUL) begin
            acc    <= mul_final;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - directed self-checking bench for alu_exec_ctrl
module tb_alu_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  alu_op;
   logic [31:0] instruction;
   logic [63:0] operand_a, operand_b;
   logic        out_valid, out_ready;
   logic [63:0] result;
   logic [3:0]  operation_code;
   logic        zero, negative, carry, overflow, illegal, busy;

   int errors = 0;
   int checks = 0;

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;
   localparam logic [10:0] OPC_MUL = 11'b10011011000;
   localparam logic [10:0] OPC_LSL = 11'b11010011011;
   localparam logic [10:0] OPC_LSR = 11'b11010011010;
   localparam logic [10:0] OPC_BAD = 11'b11111111111;

   alu_exec_ctrl #(.WIDTH(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .instruction(instruction),
      .operand_a(operand_a), .operand_b(operand_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .operation_code(operation_code),
      .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
      .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running required done");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive a request just after a falling edge, then advance to the next falling edge.
   task automatic xfer(input logic [1:0] op, input logic [10:0] opc, input logic [5:0] sh,
                       input logic [63:0] a, input logic [63:0] b);
      alu_op      = op;
      instruction = {opc, 5'd0, sh, 10'd0};
      operand_a   = a;
      operand_b   = b;
      in_valid    = 1'b1;
      #1 check("in_ready_at_req", in_ready, 1);
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic mul_run(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
      int j;
      int bad;
      xfer(2'b10, OPC_MUL, 6'd0, a, b);
      in_valid = 1'b0;
      j   = 0;
      bad = 0;
      while (!out_valid && j < 200) begin
         if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
         operand_a   = 64'hDEAD_BEEF_0BAD_F00D;
         operand_b   = 64'h1234_5678_9ABC_DEF0;
         instruction = {OPC_ADD, 21'd0};
         @(negedge clk);
         j++;
      end
      check("mul_latency", 64'(j), 64'd64);
      check("mul_busy_stall_cycles_bad", 64'(bad), 64'd0);
      check("mul_result", result, exp);
      check("mul_code", operation_code, 4'b1000);
      check("mul_busy_done", busy, 0);
      check("mul_carry", carry, 0);
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      alu_op      = 2'b00;
      instruction = '0;
      operand_a   = '0;
      operand_b   = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_code", operation_code, 0);
      check("rst_busy", busy, 0);
      check("rst_illegal", illegal, 0);
      check("rst_flags", {zero, negative, carry, overflow}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      xfer(2'b10, OPC_ADD, 6'd0, 64'd5, 64'd3);
      in_valid = 1'b0;
      check("add_valid", out_valid, 1);
      check("add_result", result, 8);
      check("add_code", operation_code, 4'b0010);
      check("add_zero", zero, 0);
      check("add_carry", carry, 0);
      @(negedge clk);
      check("add_valid_cleared", out_valid, 0);

      xfer(2'b10, OPC_SUB, 6'd0, 64'd7, 64'd7);
      in_valid = 1'b0;
      check("sub_result", result, 0);
      check("sub_zero", zero, 1);
      check("sub_carry", carry, 1);
      check("sub_code", operation_code, 4'b0110);
      check("sub_ovf", overflow, 0);

      xfer(2'b10, OPC_ADD, 6'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      in_valid = 1'b0;
      check("addov_result", result, 64'h8000_0000_0000_0000);
      check("addov_neg", negative, 1);
      check("addov_ovf", overflow, 1);
      check("addov_carry", carry, 0);

      xfer(2'b10, OPC_AND, 6'd0, 64'hF0, 64'h3C);
      check("and_result", result, 64'h30);
      xfer(2'b10, OPC_ORR, 6'd0, 64'hF0, 64'h0F);
      in_valid = 1'b0;
      check("b2b_valid", out_valid, 1);
      check("orr_result", result, 64'hFF);
      check("orr_code", operation_code, 4'b0001);
      drain();

      mul_run(64'd12, 64'd13, 64'd156);
      drain();
      mul_run(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
      drain();

      xfer(2'b10, OPC_LSL, 6'd63, 64'd1, 64'd0);
      check("lsl_result", result, 64'h8000_0000_0000_0000);
      check("lsl_code", operation_code, 4'b1001);
      xfer(2'b10, OPC_LSR, 6'd7, 64'h80, 64'd0);
      check("lsr_result", result, 1);
      check("lsr_code", operation_code, 4'b1010);
      xfer(2'b11, OPC_BAD, 6'd0, 64'd9, 64'd0);
      check("pass_result", result, 0);
      check("pass_zero", zero, 1);
      check("pass_code", operation_code, 4'b0111);
      xfer(2'b01, OPC_SUB, 6'd0, 64'd9, 64'd5);
      check("pass01_result", result, 5);
      xfer(2'b00, OPC_BAD, 6'd0, 64'd10, 64'd20);
      check("aluop00_result", result, 30);
      check("aluop00_code", operation_code, 4'b0010);
      drain();

      out_ready = 1'b0;
      xfer(2'b10, OPC_BAD, 6'd0, 64'd3, 64'd4);
      check("ill_flag", illegal, 1);
      check("ill_code", operation_code, 4'b1111);
      check("ill_result", result, 0);
      alu_op      = 2'b10;
      instruction = {OPC_ADD, 21'd0};
      operand_a   = 64'd1;
      operand_b   = 64'd1;
      for (int k = 0; k < 3; k++) begin
         check("hold_valid", out_valid, 1);
         check("hold_result", result, 0);
         check("hold_illegal", illegal, 1);
         check("hold_in_ready", in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 check("release_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("release_result", result, 2);
      check("release_valid", out_valid, 1);
      check("release_illegal", illegal, 0);
      drain();

      xfer(2'b10, OPC_MUL, 6'd0, 64'd12, 64'd13);
      in_valid = 1'b0;
      repeat (19) @(negedge clk);
      check("midmul_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_result", result, 0);
      check("abort_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      xfer(2'b10, OPC_ADD, 6'd0, 64'd2, 64'd2);
      in_valid = 1'b0;
      check("post_rst_result", result, 4);
      check("post_rst_valid", out_valid, 1);
      repeat (70) @(negedge clk);
      check("no_stray_valid", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
